// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory requester path: access sizes, FSM states, lane helpers.
package mem_pkg;

  localparam int NB_COL     = 4;
  localparam int COL_WIDTH  = 8;
  localparam int DATA_WIDTH = NB_COL * COL_WIDTH;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ACCESS    = 2'd1,
    LOAD_WAIT = 2'd2
  } lsu_state_t;

  // Misaligned half/word or the reserved size encoding.
  function automatic logic is_bad_access(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SIZE_B:  return 1'b0;
      SIZE_H:  return off[0];
      SIZE_W:  return off != 2'd0;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [NB_COL-1:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SIZE_B:  return 4'b0001 << off;
      SIZE_H:  return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  // Replicate right-aligned store data so every lane the mask can select carries it.
  function automatic logic [DATA_WIDTH-1:0] lane_data(input logic [1:0] size,
                                                      input logic [DATA_WIDTH-1:0] wdata);
    case (size)
      SIZE_B:  return {4{wdata[7:0]}};
      SIZE_H:  return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Combinational load alignment: shifts the addressed lane(s) down and sign/zero-extends.
module mem_load_align
  import mem_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] dout,
  input  logic [1:0]            off,
  input  logic [1:0]            size,
  input  logic                  uns,
  output logic [DATA_WIDTH-1:0] data
);

  logic [DATA_WIDTH-1:0] shifted;

  assign shifted = dout >> {off, 3'b000};

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    data = shifted;
    case (size)
      SIZE_B:  data = {{24{~uns & shifted[7]}}, shifted[7:0]};
      SIZE_H:  data = {{16{~uns & shifted[15]}}, shifted[15:0]};
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/mem_lsu_master.sv
// Load/store requester for the byte-write data RAM: one request in flight, registered RAM strobes.
module mem_lsu_master
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic [3:0]            mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_di,
  input  logic [31:0]           mem_dout
);

  lsu_state_t  state;
  logic [1:0]  off_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic        store_q;
  logic [31:0] load_data;

  assign req_ready = (state == IDLE);

  mem_load_align u_align (
    .dout (mem_dout),
    .off  (off_q),
    .size (size_q),
    .uns  (uns_q),
    .data (load_data)
  );

  // NOTE: all state here is sequential and uses non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mem_we    <= '0;
      mem_addr  <= '0;
      mem_di    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      off_q     <= '0;
      size_q    <= SIZE_B;
      uns_q     <= 1'b0;
      store_q   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (is_bad_access(req_size, req_addr[1:0])) begin
              // Rejected without touching the RAM; answered straight from IDLE.
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else begin
              mem_addr <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
              mem_we   <= req_we ? lane_mask(req_size, req_addr[1:0]) : 4'b0000;
              mem_di   <= lane_data(req_size, req_wdata);
              off_q    <= req_addr[1:0];
              size_q   <= req_size;
              uns_q    <= req_unsigned;
              store_q  <= req_we;
              state    <= ACCESS;
            end
          end
        end
        ACCESS: begin
          mem_we <= '0;
          if (store_q) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            state     <= IDLE;
          end else begin
            state <= LOAD_WAIT;
          end
        end
        LOAD_WAIT: begin
          rsp_valid <= 1'b1;
          rsp_rdata <= load_data;
          rsp_err   <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu_master.sv
// Bench for mem_lsu_master driving a behavioural 1 KiB byte-write, read-first RAM.
module tb_mem_lsu_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_di;
  logic [31:0] mem_dout;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_lsu_master #(.ADDR_WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_di       (mem_di),
    .mem_dout     (mem_dout)
  );

  // Read-first RAM, 256 words, registered read.
  logic [31:0] ram [0:255];
  initial for (int i = 0; i < 256; i++) ram[i] = '0;
  always @(posedge clk) begin
    mem_dout <= ram[mem_addr[9:2]];
    for (int l = 0; l < 4; l++)
      if (mem_we[l]) ram[mem_addr[9:2]][8*l +: 8] <= mem_di[8*l +: 8];
  end

  typedef struct {
    string       name;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [3:0]  exp_we;
    logic [31:0] exp_di;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Entered and left on a falling edge. Errors answer at the accept edge itself,
  // stores one edge later, loads two edges later.
  task automatic run_req(input vec_t v);
    int lat, we_cycles, rsp_cnt, exp_lat;
    logic we_bad, busy_seen;
    logic [31:0] rd;
    logic er;
    exp_lat = v.exp_err ? 0 : (v.we ? 1 : 2);
    req_we = v.we; req_size = v.size; req_unsigned = v.uns;
    req_addr = v.addr; req_wdata = v.wdata; req_valid = 1'b1;
    check({v.name, "_ready"}, {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1 req_valid = 1'b0;
    lat = -1; we_cycles = 0; rsp_cnt = 0; we_bad = 1'b0; busy_seen = 1'b0;
    rd = '0; er = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 0) busy_seen = ~req_ready;
      if (mem_we != 4'd0) begin
        we_cycles++;
        if (mem_we != v.exp_we || mem_di != v.exp_di || mem_addr != {v.addr[31:2], 2'b00})
          we_bad = 1'b1;
      end
      if (rsp_valid) begin
        rsp_cnt++;
        if (lat < 0) begin lat = c; rd = rsp_rdata; er = rsp_err; end
      end
    end
    check({v.name, "_lat"}, lat, exp_lat);
    check({v.name, "_rsp_cnt"}, rsp_cnt, 1);
    check({v.name, "_rdata"}, rd, v.exp_rdata);
    check({v.name, "_err"}, {31'd0, er}, {31'd0, v.exp_err});
    check({v.name, "_busy"}, {31'd0, busy_seen}, {31'd0, ~v.exp_err});
    check({v.name, "_we_cycles"}, we_cycles, (v.we && !v.exp_err) ? 1 : 0);
    check({v.name, "_we_lanes"}, {31'd0, we_bad}, 32'd0);
  endtask

  vec_t vecs [17];

  typedef struct { logic [31:0] rdata; logic err; } rsp_t;

  initial begin
    vec_t  v;
    rsp_t  b2b_exp [3];
    int    k, r, low;

    vecs[0]  = '{"sw_10",    1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 32'h0,        0, 4'hF, 32'hDEADBEEF};
    vecs[1]  = '{"lw_10",    0, 2'd2, 0, 32'h10, 32'h0,        32'hDEADBEEF, 0, 4'h0, 32'h0};
    vecs[2]  = '{"sb_13",    1, 2'd0, 0, 32'h13, 32'h80,       32'h0,        0, 4'h8, 32'h80808080};
    vecs[3]  = '{"lb_13",    0, 2'd0, 0, 32'h13, 32'h0,        32'hFFFFFF80, 0, 4'h0, 32'h0};
    vecs[4]  = '{"lbu_13",   0, 2'd0, 1, 32'h13, 32'h0,        32'h00000080, 0, 4'h0, 32'h0};
    vecs[5]  = '{"lw_10b",   0, 2'd2, 0, 32'h10, 32'h0,        32'h80ADBEEF, 0, 4'h0, 32'h0};
    vecs[6]  = '{"sh_16",    1, 2'd1, 0, 32'h16, 32'h8001,     32'h0,        0, 4'hC, 32'h80018001};
    vecs[7]  = '{"lh_16",    0, 2'd1, 0, 32'h16, 32'h0,        32'hFFFF8001, 0, 4'h0, 32'h0};
    vecs[8]  = '{"lhu_16",   0, 2'd1, 1, 32'h16, 32'h0,        32'h00008001, 0, 4'h0, 32'h0};
    vecs[9]  = '{"lw_12err", 0, 2'd2, 0, 32'h12, 32'h0,        32'h0,        1, 4'h0, 32'h0};
    vecs[10] = '{"sh_11err", 1, 2'd1, 0, 32'h11, 32'hFFFF,     32'h0,        1, 4'h0, 32'h0};
    vecs[11] = '{"sz3_err",  1, 2'd3, 0, 32'h00, 32'h1234,     32'h0,        1, 4'h0, 32'h0};
    vecs[12] = '{"lb_11",    0, 2'd0, 0, 32'h11, 32'h0,        32'hFFFFFFBE, 0, 4'h0, 32'h0};
    vecs[13] = '{"lhu_12",   0, 2'd1, 1, 32'h12, 32'h0,        32'h000080AD, 0, 4'h0, 32'h0};
    vecs[14] = '{"sb_14",    1, 2'd0, 0, 32'h14, 32'h7F,       32'h0,        0, 4'h1, 32'h7F7F7F7F};
    vecs[15] = '{"lw_14",    0, 2'd2, 0, 32'h14, 32'h0,        32'h8001007F, 0, 4'h0, 32'h0};
    vecs[16] = '{"lh_14",    0, 2'd1, 0, 32'h14, 32'h0,        32'h0000007F, 0, 4'h0, 32'h0};

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_mem_we", {28'd0, mem_we}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);

    for (int i = 0; i < 17; i++) run_req(vecs[i]);

    // Back-to-back: req_valid stays high across three requests.
    vecs[0]  = '{"b0", 1, 2'd2, 0, 32'h20, 32'h11223344, 32'h0, 0, 4'hF, 32'h11223344};
    vecs[1]  = '{"b1", 0, 2'd2, 0, 32'h20, 32'h0,        32'h0, 0, 4'h0, 32'h0};
    vecs[2]  = '{"b2", 1, 2'd0, 0, 32'h21, 32'h55,       32'h0, 0, 4'h2, 32'h55555555};
    b2b_exp[0] = '{32'h0, 1'b0};
    b2b_exp[1] = '{32'h11223344, 1'b0};
    b2b_exp[2] = '{32'h0, 1'b0};
    k = 0; r = 0; low = 0;
    req_we = vecs[0].we; req_size = vecs[0].size; req_unsigned = vecs[0].uns;
    req_addr = vecs[0].addr; req_wdata = vecs[0].wdata; req_valid = 1'b1;
    for (int c = 0; c < 30 && r < 3; c++) begin
      if (rsp_valid) begin
        check($sformatf("b2b_rdata%0d", r), rsp_rdata, b2b_exp[r].rdata);
        check($sformatf("b2b_err%0d", r), {31'd0, rsp_err}, {31'd0, b2b_exp[r].err});
        r++;
      end
      if (!req_ready) low++;
      if (req_valid && req_ready) begin
        if (k > 0) check($sformatf("b2b_overlap%0d", k), {31'd0, rsp_valid}, 32'd1);
        @(posedge clk); #1;
        k++;
        if (k < 3) begin
          req_we = vecs[k].we; req_size = vecs[k].size; req_unsigned = vecs[k].uns;
          req_addr = vecs[k].addr; req_wdata = vecs[k].wdata;
        end else begin
          req_valid = 1'b0;
        end
      end
      @(negedge clk);
    end
    check("b2b_accepts", k, 3);
    check("b2b_responses", r, 3);
    check("b2b_busy_cycles", low, 4);
    v = '{"lw_20", 0, 2'd2, 0, 32'h20, 32'h0, 32'h11225544, 0, 4'h0, 32'h0};
    run_req(v);

    // Reset while the load sits in LOAD_WAIT: its response must vanish.
    req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h10; req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("mid_rst_ready", {31'd0, req_ready}, 32'd1);
    check("mid_rst_mem_we", {28'd0, mem_we}, 32'd0);
    check("mid_rst_mem_addr", mem_addr, 32'd0);
    check("mid_rst_mem_di", mem_di, 32'd0);
    check("mid_rst_rdata", rsp_rdata, 32'd0);
    check("mid_rst_err", {31'd0, rsp_err}, 32'd0);
    r = 0;
    for (int c = 0; c < 4; c++) begin
      if (rsp_valid) r++;
      @(negedge clk);
    end
    check("mid_rst_no_rsp", r, 0);
    v = '{"lw_after_rst", 0, 2'd2, 0, 32'h10, 32'h0, 32'h80ADBEEF, 0, 4'h0, 32'h0};
    run_req(v);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Hard stop if anything above stalls.
  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete, got hang expected finish");
    $fatal(1);
  end

endmodule
